// File: rtl/maze_map_loader.sv
// maze_map_loader
//
// Loads an N x N maze wall map (N = 2**CW) one row per valid/ready handshake,
// checks that the start cell (0,0) and goal cell (N-1,N-1) are open, then
// serves combinational wall lookups at (X,Y). While the map is done, the
// controller may mark cells as blocked (visited).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   load_start   pulse: begin (re)load of the full map
//   row_data     one maze row; bit x = cell (x, row); 1 = wall
//   row_valid    row_data valid
//   row_ready    loader accepts a row this cycle (registered)
//   X, Y         lookup/mark column and row
//   mark_en      set cell (X,Y) to 1, honoured only once the map is done
//   wall         map[Y][X], combinational
//   map_ready    map loaded and checked; solver may run
//   map_error    start or goal cell is a wall after load
//   rows_loaded  rows accepted in the current load

module maze_map_loader #(
    parameter int unsigned CW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [(1<<CW)-1:0]   row_data,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [CW-1:0]        X,
    input  logic [CW-1:0]        Y,
    input  logic                 mark_en,
    output logic                 wall,
    output logic                 map_ready,
    output logic                 map_error,
    output logic [CW:0]          rows_loaded
);

    localparam int unsigned N = 1 << CW;

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_t;

    state_t          state;
    logic [CW-1:0]   row_cnt;
    logic [N-1:0]    map_mem [N];

    assign wall = map_mem[Y][X];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            row_cnt     <= '0;
            row_ready   <= 1'b0;
            map_ready   <= 1'b0;
            map_error   <= 1'b0;
            rows_loaded <= '0;
            for (int i = 0; i < N; i++) begin
                map_mem[i] <= '0;
            end
        end else if (load_start) begin
            // Restart wins over a coincident handshake: the row is dropped.
            // Old map contents stay; the new load overwrites them row by row.
            state       <= StLoad;
            row_cnt     <= '0;
            row_ready   <= 1'b1;
            map_ready   <= 1'b0;
            map_error   <= 1'b0;
            rows_loaded <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    row_ready <= 1'b0;
                end
                StLoad: begin
                    if (row_valid && row_ready) begin
                        map_mem[row_cnt] <= row_data;
                        rows_loaded      <= rows_loaded + (CW+1)'(1);
                        if (row_cnt == CW'(N - 1)) begin
                            // Counter holds at N-1 rather than wrapping.
                            state     <= StCheck;
                            row_ready <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + CW'(1);
                        end
                    end
                end
                StCheck: begin
                    map_error <= map_mem[0][0] | map_mem[N-1][N-1];
                    state     <= StDone;
                end
                StDone: begin
                    // Registered here so ready rises one cycle after DONE entry.
                    map_ready <= 1'b1;
                    if (mark_en) begin
                        map_mem[Y][X] <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
